// File: rtl/serial_adder_sub_if.sv
// serial_adder_sub_if: operand and result handshake bundle
// for the digit-serial adder/subtractor.
interface serial_adder_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: digit-serial WIDTH-bit add/sub, DIGIT bits/cycle.
// Define SERIAL_ADDER_SAT_EN for signed saturation on overflow.
module serial_adder_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_sub_if.slave io
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] dsum_ext;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             dovf;
  logic             accept;
  logic             last;

  assign accept = (state_q == IDLE) && io.in_valid;
  assign last   = (state_q == RUN) && (cnt == CW'(NDIG - 1));

  // Ripple full-adder chain over the low digit of the operands
  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1]   = (a_sh[i] & b_sh[i])
               | (c[i] & (a_sh[i] ^ b_sh[i]));
    end
  end

  // Carry into the MSB only matters on the last digit,
  // where bit DIGIT-1 of the chain is bit WIDTH-1 overall.
  assign dovf     = c[DIGIT] ^ c[DIGIT-1];
  assign dsum_ext = WIDTH'(dsum);
  assign acc_nxt  = (acc >> DIGIT)
                  | (dsum_ext << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow both operand signs agree; A's MSB picks the rail
  always_comb begin
    res = acc_nxt;
    if (dovf)
      res = a_sh[DIGIT-1] ? MIN_NEG : MAX_POS;
  end
`else
  assign res = acc_nxt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= io.a;
      b_sh  <= io.sub ? ~io.b : io.b;
      carry <= io.sub ^ io.cin;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_nxt;
      carry <= c[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_q  <= res;
        cout_q <= c[DIGIT];
        ovf_q  <= dovf;
      end
    end
  end

  assign io.sum  = sum_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: directed vectors for 8x1 and 16x4 builds.
// Expectations follow SERIAL_ADDER_SAT_EN when defined.
module tb_serial_adder_sub;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_adder_sub_if #(.WIDTH(8))  bus8 ();
  serial_adder_sub_if #(.WIDTH(16)) bus16 ();

  serial_adder_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus8)
  );

  serial_adder_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue8(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       sub,
    output int         lat
  );
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.sub      = sub;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release8;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset8_hs: rdy=%b vld=%b want 1 0",
               bus8.in_ready, bus8.out_valid);
    end
    tests++;
    if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0
        || bus8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset8_out: sum=%h c=%b v=%b want 00 0 0",
               bus8.sum, bus8.cout, bus8.ovf);
    end
    tests++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0
        || bus16.sum !== 16'h0000) begin
      fails++;
      $display("FAIL reset16: rdy=%b vld=%b sum=%h want 1 0 0000",
               bus16.in_ready, bus16.out_valid, bus16.sum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat;
    issue8(8'h0F, 8'h01, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 8) begin
      fails++;
      $display("FAIL add_latency: got %0d want 8", lat);
    end
    tests++;
    if (bus8.sum !== 8'h10 || bus8.cout !== 1'b0
        || bus8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL add_result: sum=%h c=%b v=%b want 10 0 0",
               bus8.sum, bus8.cout, bus8.ovf);
    end
    release8();
    tests++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL add_return: vld=%b rdy=%b want 0 1",
               bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_overflow;
    int         lat;
    logic [7:0] exp_sum;
`ifdef SERIAL_ADDER_SAT_EN
    exp_sum = 8'h7F;
`else
    exp_sum = 8'h80;
`endif
    issue8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 8 || bus8.sum !== exp_sum || bus8.cout !== 1'b0
        || bus8.ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_add: lat=%0d sum=%h c=%b v=%b want 8 %h 0 1",
               lat, bus8.sum, bus8.cout, bus8.ovf, exp_sum);
    end
    release8();
  endtask

  task automatic test_carry_sub;
    int lat;
    issue8(8'hFF, 8'h01, 1'b1, 1'b0, lat);
    tests++;
    if (lat !== 8 || bus8.sum !== 8'h01 || bus8.cout !== 1'b1
        || bus8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL carry_add: lat=%0d sum=%h c=%b v=%b want 8 01 1 0",
               lat, bus8.sum, bus8.cout, bus8.ovf);
    end
    release8();
    issue8(8'h05, 8'h07, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 8 || bus8.sum !== 8'hFE || bus8.cout !== 1'b0
        || bus8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL sub_borrow: lat=%0d sum=%h c=%b v=%b want 8 FE 0 0",
               lat, bus8.sum, bus8.cout, bus8.ovf);
    end
    release8();
    issue8(8'h80, 8'h01, 1'b0, 1'b1, lat);
    tests++;
`ifdef SERIAL_ADDER_SAT_EN
    if (bus8.sum !== 8'h80 || bus8.cout !== 1'b1
        || bus8.ovf !== 1'b1) begin
      fails++;
      $display("FAIL sub_ovf: sum=%h c=%b v=%b want 80 1 1",
               bus8.sum, bus8.cout, bus8.ovf);
    end
`else
    if (bus8.sum !== 8'h7F || bus8.cout !== 1'b1
        || bus8.ovf !== 1'b1) begin
      fails++;
      $display("FAIL sub_ovf: sum=%h c=%b v=%b want 7F 1 1",
               bus8.sum, bus8.cout, bus8.ovf);
    end
`endif
    release8();
  endtask

  task automatic test_backpressure;
    int lat;
    issue8(8'h12, 8'h34, 1'b0, 1'b0, lat);
    bus8.a        = 8'h20;
    bus8.b        = 8'h03;
    bus8.cin      = 1'b0;
    bus8.sub      = 1'b1;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0
          || bus8.sum !== 8'h46) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h want 1 0 46",
                 i, bus8.out_valid, bus8.in_ready, bus8.sum);
      end
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    tests++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_idle: vld=%b rdy=%b want 0 1",
               bus8.out_valid, bus8.in_ready);
    end
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    tests++;
    if (bus8.in_ready !== 1'b0 || bus8.sum !== 8'h46) begin
      fails++;
      $display("FAIL bp_accept: rdy=%b sum=%h want 0 46",
               bus8.in_ready, bus8.sum);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) begin
        lat = n;
        break;
      end
    end
    tests++;
    if (lat !== 8 || bus8.sum !== 8'h1D || bus8.cout !== 1'b1
        || bus8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL bp_pending: lat=%0d sum=%h c=%b v=%b want 8 1D 1 0",
               lat, bus8.sum, bus8.cout, bus8.ovf);
    end
    release8();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bus8.a        = 8'hF0;
    bus8.b        = 8'h0F;
    bus8.cin      = 1'b1;
    bus8.sub      = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0
        || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rdy=%b vld=%b sum=%h c=%b want 1 0 00 0",
               bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'h33, 8'h11, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 8 || bus8.sum !== 8'h22 || bus8.cout !== 1'b1
        || bus8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: lat=%0d sum=%h c=%b v=%b want 8 22 1 0",
               lat, bus8.sum, bus8.cout, bus8.ovf);
    end
    release8();
  endtask

  task automatic test_wide;
    int          lat;
    logic [15:0] exp_sum;
`ifdef SERIAL_ADDER_SAT_EN
    exp_sum = 16'h8000;
`else
    exp_sum = 16'h0000;
`endif
    bus16.a        = 16'h8000;
    bus16.b        = 16'h8000;
    bus16.cin      = 1'b0;
    bus16.sub      = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus16.out_valid) begin
        lat = n;
        break;
      end
    end
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL wide_latency: got %0d want 4", lat);
    end
    tests++;
    if (bus16.sum !== exp_sum || bus16.cout !== 1'b1
        || bus16.ovf !== 1'b1) begin
      fails++;
      $display("FAIL wide_result: sum=%h c=%b v=%b want %h 1 1",
               bus16.sum, bus16.cout, bus16.ovf, exp_sum);
    end
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    tests++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL wide_return: vld=%b rdy=%b want 0 1",
               bus16.out_valid, bus16.in_ready);
    end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.cin        = 1'b0;
    bus8.sub        = 1'b0;
    bus8.out_ready  = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.cin       = 1'b0;
    bus16.sub       = 1'b0;
    bus16.out_ready = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_carry_sub();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
Parametrised, multi-cycle, digit-serial adder/subtractor. It is the sequential successor to the single-bit half/full adder cells. Each cycle it processes DIGIT bits of a WIDTH-bit operand pair through a DIGIT-wide ripple full-adder chain, with a registered carry between cycles. Operands enter through a valid/ready handshake and results leave through another, so the block can sit between register stages of a small datapath.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 2.
DIGIT, 1, bits processed per cycle; WIDTH must be an exact multiple of DIGIT. NDIG = WIDTH/DIGIT.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a, b, cin, sub are valid.
in_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in when adding; borrow-in when subtracting.
sub  input  1  0 = A+B+cin; 1 = A-B-cin.
out_valid  output  1  result fields are valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry-out of the MSB. In sub mode, 1 = no borrow.
ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async assert, rst_n low): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; digit counter=0; internal carry=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and (sub ? ~b : b). Set carry = sub ? ~cin : cin. Counter=0. Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, add the low DIGIT bits of the A and B shift registers plus carry. Shift the DIGIT result bits into sum from the MSB end. Shift both operand registers right by DIGIT. Update carry. Increment the counter.
    - On the last digit (counter==NDIG-1), also capture the carry into bit WIDTH-1. Go to DONE.
  - DONE: out_valid=1. sum, cout and ovf are stable and held. cout = final carry. ovf = carry into MSB XOR carry out of MSB.
    - On out_ready: out_valid drops next cycle and the block returns to IDLE.
    - Without out_ready: hold indefinitely.
- Latency: operands accepted at edge k. out_valid is high from edge k+NDIG. Throughput is one operation per NDIG+2 cycles minimum (IDLE accept, NDIG RUN cycles, DONE handshake).
- sum/cout/ovf change only on the RUN->DONE transition. They keep the previous result in IDLE and RUN; sum's internal shift register is separate from the output register.
- in_valid while not IDLE: ignored. Inputs must be held by the source until accepted.
- out_ready in IDLE/RUN: ignored.
- Arithmetic is modulo 2^WIDTH. sub=1, cin=0 gives A-B exactly; cout=0 means A<B as unsigned.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all outputs return to reset values asynchronously. Deassertion is synchronous to clk; the first accept can happen on the first edge after release.

Optional Feature:
SERIAL_ADDER_SAT_EN:
- Defined: signed saturation. When ovf=1, sum is forced to 2^(WIDTH-1)-1 if the true result is positive (operand sign bits 0 after B inversion), or to -2^(WIDTH-1) if negative. ovf still reports 1; cout is unaffected.
- Undefined: sum is the wrapped modulo result and no saturation logic is present.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x0F, b=0x01, cin=0, sub=0 accepted at edge k -> out_valid at edge k+8, sum=0x10, cout=0, ovf=0.
- a=0x7F, b=0x01, add -> sum=0x80, ovf=1, cout=0. With SERIAL_ADDER_SAT_EN defined -> sum=0x7F, ovf=1.
- a=0xFF, b=0x01, cin=1, add -> sum=0x01, cout=1, ovf=0. Then sub: a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/out_valid stable, in_ready=0, a new in_valid ignored. Raise out_ready -> IDLE next cycle, then the pending operand is accepted.
- Reset: pull rst_n low at RUN cycle 3 -> in_ready=1, out_valid=0, sum=0 immediately. A new operation after release completes correctly.
- WIDTH=16, DIGIT=4: a=0x8000, b=0x8000, add -> latency 4 cycles, sum=0x0000, cout=1, ovf=1.
